// File: rtl/mem_req_scheduler.sv
// Schedules WB / DF / IF line requests onto one outstanding Sysbus transaction:
// one holding slot per requester, aging-based starvation escape, WB-before-fill line hazard.
module mem_req_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int LINE_BYTES   = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wb_valid,
    output logic         wb_ready,
    input  logic [63:0]  wb_addr,
    input  logic [511:0] wb_wdata,
    output logic         wb_done,
    input  logic         df_valid,
    output logic         df_ready,
    input  logic [63:0]  df_addr,
    output logic         df_done,
    output logic [511:0] df_rdata,
    input  logic         if_valid,
    output logic         if_ready,
    input  logic [63:0]  if_addr,
    output logic         if_done,
    output logic [511:0] if_rdata,
    output logic         mem_req,
    input  logic         mem_reqack,
    output logic         mem_wr,
    output logic [63:0]  mem_addr,
    output logic [511:0] mem_wdata,
    input  logic [511:0] mem_rdata,
    input  logic         mem_done,
    output logic         proto_err
);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);
    localparam logic [63:0] LINE_MASK = ~(64'(LINE_BYTES) - 64'd1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_DF = 2'd0, OWN_IF = 2'd1, OWN_WB = 2'd2} owner_t;
    typedef struct packed {
        logic             vld;
        logic [63:0]      addr;
        logic [AGE_W-1:0] age;
    } slot_t;

    state_t       state, state_nx;
    owner_t       owner, win;
    slot_t        slot [3];
    logic [511:0] wb_data;
    logic [2:0]   elig, starve;
    logic         grant;

    assign df_ready = !slot[OWN_DF].vld && !reset;
    assign if_ready = !slot[OWN_IF].vld && !reset;
    assign wb_ready = !slot[OWN_WB].vld && !reset;

    // A fill must not overtake a queued/in-flight writeback of the same line.
    always_comb begin
        elig[OWN_DF] = slot[OWN_DF].vld &&
                       !(slot[OWN_WB].vld && slot[OWN_WB].addr == slot[OWN_DF].addr);
        elig[OWN_IF] = slot[OWN_IF].vld &&
                       !(slot[OWN_WB].vld && slot[OWN_WB].addr == slot[OWN_IF].addr);
        elig[OWN_WB] = slot[OWN_WB].vld;
        for (int i = 0; i < 3; i++) starve[i] = elig[i] && (slot[i].age == AGE_MAX);
        grant = |elig;
        win   = OWN_DF;
        if      (starve[OWN_DF]) win = OWN_DF;
        else if (starve[OWN_IF]) win = OWN_IF;
        else if (starve[OWN_WB]) win = OWN_WB;
        else if (elig[OWN_DF])   win = OWN_DF;
        else if (elig[OWN_IF])   win = OWN_IF;
        else if (elig[OWN_WB])   win = OWN_WB;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant)      state_nx = ISSUE;
            ISSUE:   if (mem_reqack) state_nx = WAIT;
            WAIT:    if (mem_done)   state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_DF;
            for (int i = 0; i < 3; i++) slot[i] <= '0;
            wb_data   <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_done   <= 1'b0;
            df_done   <= 1'b0;
            if_done   <= 1'b0;
            df_rdata  <= '0;
            if_rdata  <= '0;
            proto_err <= 1'b0;
        end else begin
            state    <= state_nx;
            wb_done  <= 1'b0;
            df_done  <= 1'b0;
            if_done  <= 1'b0;
            df_rdata <= '0;
            if_rdata <= '0;

            if (wb_valid && wb_ready) begin
                slot[OWN_WB].vld  <= 1'b1;
                slot[OWN_WB].addr <= wb_addr & LINE_MASK;
                wb_data           <= wb_wdata;
            end
            if (df_valid && df_ready) begin
                slot[OWN_DF].vld  <= 1'b1;
                slot[OWN_DF].addr <= df_addr & LINE_MASK;
            end
            if (if_valid && if_ready) begin
                slot[OWN_IF].vld  <= 1'b1;
                slot[OWN_IF].addr <= if_addr & LINE_MASK;
            end

            case (state)
                IDLE: if (grant) begin
                    owner     <= win;
                    mem_req   <= 1'b1;
                    mem_wr    <= (win == OWN_WB);
                    mem_addr  <= slot[win].addr;
                    mem_wdata <= (win == OWN_WB) ? wb_data : '0;
                    // Ages count grants lost while waiting; the winner starts over.
                    for (int i = 0; i < 3; i++) begin
                        if (i == int'(win))
                            slot[i].age <= '0;
                        else if (slot[i].vld && slot[i].age != AGE_MAX)
                            slot[i].age <= slot[i].age + 1'b1;
                    end
                end
                ISSUE: if (mem_reqack) mem_req <= 1'b0;
                WAIT: if (mem_done) begin
                    slot[owner].vld <= 1'b0;
                    case (owner)
                        OWN_WB:  wb_done <= 1'b1;
                        OWN_DF:  begin df_done <= 1'b1; df_rdata <= mem_rdata; end
                        OWN_IF:  begin if_done <= 1'b1; if_rdata <= mem_rdata; end
                        default: ;
                    endcase
                end
                default: ;
            endcase

            if ((mem_done && state != WAIT) || (mem_reqack && state != ISSUE))
                proto_err <= 1'b1;
        end
    end
endmodule
